// File: rtl/host_plane_rr_scheduler.sv
// host_plane_rr_scheduler: per-plane host pending bitmaps with two-level round-robin grants
// Ports: i_clk/i_rst_n clock and async active-low reset; i_upd_* / o_upd_ready set or clear one
// bit of one plane row; i_gnt_req / o_gnt_valid / i_gnt_ready / o_gnt_*_id grant handshake;
// o_active_planes counts nonzero rows; o_busy is high outside IDLE.
module host_plane_rr_scheduler #(
  parameter int MAX_HOST_NUMBER    = 8,
  parameter int MAX_PLANE_NUMBER   = 3,
  parameter int HOST_ID_BIT_WIDTH  = $clog2(MAX_HOST_NUMBER),
  parameter int PLANE_ID_BIT_WIDTH = $clog2(MAX_PLANE_NUMBER),
  parameter bit AUTO_CLEAR         = 1'b1
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_upd_valid,
  output logic                          o_upd_ready,
  input  logic                          i_upd_op,
  input  logic [HOST_ID_BIT_WIDTH-1:0]  i_upd_host_id,
  input  logic [PLANE_ID_BIT_WIDTH-1:0] i_upd_plane_id,
  input  logic                          i_gnt_req,
  output logic                          o_gnt_valid,
  input  logic                          i_gnt_ready,
  output logic [HOST_ID_BIT_WIDTH-1:0]  o_gnt_host_id,
  output logic [PLANE_ID_BIT_WIDTH-1:0] o_gnt_plane_id,
  output logic [PLANE_ID_BIT_WIDTH:0]   o_active_planes,
  output logic                          o_busy
);
  localparam int H  = MAX_HOST_NUMBER;
  localparam int P  = MAX_PLANE_NUMBER;
  localparam int HW = HOST_ID_BIT_WIDTH;
  localparam int PW = PLANE_ID_BIT_WIDTH;
  localparam logic [PW:0] CNT_ONE = (PW+1)'(1);
  localparam logic [H-1:0] BIT0 = H'(1);

  typedef enum logic [5:0] {
    IDLE     = 6'b000001,
    UPD_RD   = 6'b000010,
    UPD_WR   = 6'b000100,
    SCAN_RD  = 6'b001000,
    SCAN_CHK = 6'b010000,
    GRANT    = 6'b100000
  } state_t;

  state_t state, state_nx;
  logic [H-1:0]  mem      [P];
  logic [HW-1:0] host_ptr [P];
  logic [PW-1:0] plane_ptr;
  logic [H-1:0]  rd_data;
  logic          upd_op;
  logic [HW-1:0] upd_host;
  logic [PW-1:0] upd_plane;
  logic          pref_upd;
  logic          gnt_win, upd_take, upd_in_range;
  logic [HW-1:0] sel_host;
  logic [H-1:0]  upd_mask, new_row, clr_row;

  function automatic logic [PW-1:0] nxt_plane(input logic [PW-1:0] p);
    return (int'(p) == P - 1) ? '0 : p + PW'(1);
  endfunction

  // Fairness: pref_upd remembers which side lost the last contended (or uncontended) service.
  always_comb begin
    gnt_win      = (state == IDLE) && i_gnt_req && (o_active_planes != '0) && (!i_upd_valid || !pref_upd);
    o_upd_ready  = i_rst_n && (state == IDLE) && !gnt_win;
    upd_take     = i_upd_valid && o_upd_ready;
    o_gnt_valid  = (state == GRANT);
    o_busy       = (state != IDLE);
    upd_in_range = int'(upd_plane) < P;
    upd_mask     = BIT0 << upd_host;
    new_row      = upd_op ? (rd_data | upd_mask) : (rd_data & ~upd_mask);
    clr_row      = rd_data & ~(BIT0 << o_gnt_host_id);
  end

  // Circular search starting just after the plane's host pointer; the pointer itself is tested last.
  always_comb begin
    int idx;
    logic found;
    idx      = 0;
    found    = 1'b0;
    sel_host = '0;
    for (int i = 1; i <= H; i++) begin
      idx = (int'(host_ptr[plane_ptr]) + i) % H;
      if (!found && rd_data[idx]) begin
        sel_host = HW'(idx);
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     state_nx = gnt_win ? SCAN_RD : (upd_take ? UPD_RD : IDLE);
      UPD_RD:   state_nx = UPD_WR;
      UPD_WR:   state_nx = IDLE;
      SCAN_RD:  state_nx = SCAN_CHK;
      SCAN_CHK: state_nx = !i_gnt_req ? IDLE : (|rd_data ? GRANT : SCAN_RD);
      GRANT:    state_nx = i_gnt_ready ? IDLE : GRANT;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= IDLE;
      for (int p = 0; p < P; p++) begin
        mem[p]      <= '0;
        host_ptr[p] <= HW'(H - 1);
      end
      plane_ptr       <= '0;
      rd_data         <= '0;
      upd_op          <= 1'b0;
      upd_host        <= '0;
      upd_plane       <= '0;
      pref_upd        <= 1'b1;
      o_gnt_host_id   <= '0;
      o_gnt_plane_id  <= '0;
      o_active_planes <= '0;
    end else begin
      state <= state_nx;
      if (upd_take) begin
        upd_op    <= i_upd_op;
        upd_host  <= i_upd_host_id;
        upd_plane <= i_upd_plane_id;
      end
      if (gnt_win || upd_take) pref_upd <= gnt_win;
      if (state == UPD_RD) rd_data <= upd_in_range ? mem[upd_plane] : '0;
      if (state == UPD_WR && upd_in_range) begin
        mem[upd_plane] <= new_row;
        if (rd_data == '0 && new_row != '0) o_active_planes <= o_active_planes + CNT_ONE;
        else if (rd_data != '0 && new_row == '0) o_active_planes <= o_active_planes - CNT_ONE;
      end
      if (state == SCAN_RD) rd_data <= mem[plane_ptr];
      if (state == SCAN_CHK && i_gnt_req) begin
        if (|rd_data) begin
          o_gnt_host_id  <= sel_host;
          o_gnt_plane_id <= plane_ptr;
        end else plane_ptr <= nxt_plane(plane_ptr);
      end
      // rd_data still holds the granted row: nothing writes the bitmap between SCAN_RD and GRANT.
      if (state == GRANT && i_gnt_ready) begin
        host_ptr[o_gnt_plane_id] <= o_gnt_host_id;
        plane_ptr                <= nxt_plane(o_gnt_plane_id);
        if (AUTO_CLEAR) begin
          mem[o_gnt_plane_id] <= clr_row;
          if (rd_data != '0 && clr_row == '0) o_active_planes <= o_active_planes - CNT_ONE;
        end
      end
    end
  end
endmodule

// File: tb/tb_host_plane_rr_scheduler.sv
// tb_host_plane_rr_scheduler: directed bench with a transaction-level bitmap model and per-cycle compare
module tb_host_plane_rr_scheduler;
  localparam int H  = 8;
  localparam int P  = 3;
  localparam int HW = 3;
  localparam int PW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic a_upd_valid = 0, a_upd_op = 0, a_gnt_req = 0, a_gnt_ready = 0;
  logic [HW-1:0] a_upd_host = 0;
  logic [PW-1:0] a_upd_plane = 0;
  logic a_upd_ready, a_gnt_valid, a_busy;
  logic [HW-1:0] a_gnt_host;
  logic [PW-1:0] a_gnt_plane;
  logic [PW:0]   a_active;

  logic b_upd_valid = 0, b_upd_op = 0, b_gnt_req = 0, b_gnt_ready = 0;
  logic [HW-1:0] b_upd_host = 0;
  logic [PW-1:0] b_upd_plane = 0;
  logic b_upd_ready, b_gnt_valid, b_busy;
  logic [HW-1:0] b_gnt_host;
  logic [PW-1:0] b_gnt_plane;
  logic [PW:0]   b_active;

  host_plane_rr_scheduler #(.MAX_HOST_NUMBER(H), .MAX_PLANE_NUMBER(P), .AUTO_CLEAR(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_upd_valid(a_upd_valid), .o_upd_ready(a_upd_ready),
    .i_upd_op(a_upd_op), .i_upd_host_id(a_upd_host), .i_upd_plane_id(a_upd_plane),
    .i_gnt_req(a_gnt_req), .o_gnt_valid(a_gnt_valid), .i_gnt_ready(a_gnt_ready),
    .o_gnt_host_id(a_gnt_host), .o_gnt_plane_id(a_gnt_plane), .o_active_planes(a_active), .o_busy(a_busy));

  host_plane_rr_scheduler #(.MAX_HOST_NUMBER(H), .MAX_PLANE_NUMBER(P), .AUTO_CLEAR(1'b0)) dut_nc (
    .i_clk(clk), .i_rst_n(rst_n), .i_upd_valid(b_upd_valid), .o_upd_ready(b_upd_ready),
    .i_upd_op(b_upd_op), .i_upd_host_id(b_upd_host), .i_upd_plane_id(b_upd_plane),
    .i_gnt_req(b_gnt_req), .o_gnt_valid(b_gnt_valid), .i_gnt_ready(b_gnt_ready),
    .o_gnt_host_id(b_gnt_host), .o_gnt_plane_id(b_gnt_plane), .o_active_planes(b_active), .o_busy(b_busy));

  int n_cmp = 0;
  int n_bad = 0;

  logic [H-1:0] m_map [P];
  int m_hptr [P];
  int m_pptr;
  string svc_log = "";
  int gh[$], gp[$], bh[$], bp[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Next grant from the model: first nonzero plane from the plane pointer, then the nearest set host after the plane's pointer.
  function automatic void predict(output bit found, output int pl, output int ho);
    found = 0; pl = 0; ho = 0;
    for (int k = 0; k < P; k++) begin
      if (!found && m_map[(m_pptr + k) % P] != '0) begin
        found = 1;
        pl = (m_pptr + k) % P;
        for (int i = H; i >= 1; i--)
          if (m_map[pl][(m_hptr[pl] + i) % H]) ho = (m_hptr[pl] + i) % H;
      end
    end
  endfunction

  function automatic int rows_set();
    int n = 0;
    for (int p = 0; p < P; p++) if (m_map[p] != '0) n++;
    return n;
  endfunction

  always @(negedge clk) begin
    bit f;
    int pl, ho;
    if (!rst_n) begin
      for (int p = 0; p < P; p++) begin
        m_map[p]  = '0;
        m_hptr[p] = H - 1;
      end
      m_pptr = 0;
      chk("reset_outputs", int'({a_upd_ready, a_gnt_valid, a_busy, a_active, a_gnt_host, a_gnt_plane}), 0);
    end else begin
      if (!a_busy) chk("active_planes", int'(a_active), rows_set());
      if (a_gnt_valid) begin
        predict(f, pl, ho);
        chk("grant_expected", int'(f), 1);
        chk("grant_host", int'(a_gnt_host), ho);
        chk("grant_plane", int'(a_gnt_plane), pl);
        if (a_gnt_ready) begin
          gh.push_back(int'(a_gnt_host));
          gp.push_back(int'(a_gnt_plane));
          svc_log = {svc_log, "G"};
          if (f) begin
            m_hptr[pl] = ho;
            m_pptr = (pl + 1) % P;
            m_map[pl][ho] = 1'b0;
          end
        end
      end
      if (a_upd_valid && a_upd_ready) begin
        svc_log = {svc_log, "U"};
        if (int'(a_upd_plane) < P) m_map[a_upd_plane][a_upd_host] = a_upd_op;
      end
      if (b_gnt_valid && b_gnt_ready) begin
        bh.push_back(int'(b_gnt_host));
        bp.push_back(int'(b_gnt_plane));
      end
    end
  end

  task automatic upd(input bit sel, input bit op, input int h, input int p);
    bit ok = 0;
    @(posedge clk); #1;
    if (sel) begin
      b_upd_valid = 1; b_upd_op = op; b_upd_host = HW'(h); b_upd_plane = PW'(p);
    end else begin
      a_upd_valid = 1; a_upd_op = op; a_upd_host = HW'(h); a_upd_plane = PW'(p);
    end
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (sel ? b_upd_ready : a_upd_ready) begin
        ok = 1;
        break;
      end
    end
    chk("upd_accepted", int'(ok), 1);
    @(posedge clk); #1;
    if (sel) b_upd_valid = 0; else a_upd_valid = 0;
  endtask

  task automatic wait_idle(input bit sel, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sel ? b_busy : a_busy) && n < 100);
  endtask

  task automatic grant_latency(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!a_gnt_valid && n < 60);
  endtask

  initial begin
    int lat, n, eh[3], ep[3], bhx[4];
    bit seen;
    string exp_s;
    #1 rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // Empty bitmap: a held request must never produce a grant.
    a_gnt_req = 1; a_gnt_ready = 1; seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (a_gnt_valid) seen = 1;
    end
    chk("empty_no_grant", int'(seen), 0);
    chk("empty_active", int'(a_active), 0);
    chk("empty_busy", int'(a_busy), 0);
    @(posedge clk); #1 a_gnt_req = 0;

    // Two-level round robin over planes 0 and 1.
    upd(0, 1, 5, 1); upd(0, 1, 2, 1); upd(0, 1, 7, 0);
    wait_idle(0, n);
    chk("t2_active", int'(a_active), 2);
    @(posedge clk); #1 a_gnt_req = 1;
    grant_latency(n);
    chk("t2_first_latency", n - 1, 3);
    repeat (30) @(negedge clk);
    @(posedge clk); #1 a_gnt_req = 0;
    eh = '{7, 2, 5}; ep = '{0, 1, 1};
    chk("t2_grant_count", gh.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("t2_grant_host", i < gh.size() ? gh[i] : -1, eh[i]);
      chk("t2_grant_plane", i < gp.size() ? gp[i] : -1, ep[i]);
    end
    chk("t2_active_end", int'(a_active), 0);
    gh.delete(); gp.delete();

    // No auto-clear: host pointer wraps and persists on plane 2.
    upd(1, 1, 0, 2); upd(1, 1, 3, 2); upd(1, 1, 6, 2);
    wait_idle(1, n);
    chk("t3_active", int'(b_active), 1);
    @(posedge clk); #1 b_gnt_req = 1; b_gnt_ready = 1;
    n = 0;
    while (bh.size() < 4 && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1 b_gnt_req = 0;
    bhx = '{0, 3, 6, 0};
    chk("t3_grant_count_min4", int'(bh.size() >= 4), 1);
    for (int i = 0; i < 4; i++) begin
      chk("t3_grant_host", i < bh.size() ? bh[i] : -1, bhx[i]);
      chk("t3_grant_plane", i < bp.size() ? bp[i] : -1, 2);
    end

    // Fairness after reset: update first, then alternate.
    @(posedge clk); #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    svc_log = "";
    a_gnt_req = 1; a_gnt_ready = 1;
    upd(0, 1, 1, 0); upd(0, 1, 2, 1); upd(0, 1, 3, 2); upd(0, 1, 4, 0);
    n = 0;
    while ((svc_log.len() < 8 || a_busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1 a_gnt_req = 0;
    exp_s = "UGUGUGUG";
    for (int i = 0; i < 8; i++)
      chk("t4_service_order", i < svc_log.len() ? int'(svc_log[i]) : 0, int'(exp_s[i]));
    chk("t4_active", int'(a_active), 0);
    gh.delete(); gp.delete();

    // Redundant and out-of-range updates leave the state alone.
    upd(0, 1, 6, 2);
    wait_idle(0, n);
    upd(0, 0, 0, 0);
    wait_idle(0, n);
    chk("t5_clear_absent_cycles", n, 3);
    chk("t5_clear_absent_active", int'(a_active), 1);
    upd(0, 1, 6, 2);
    wait_idle(0, n);
    chk("t5_set_present_cycles", n, 3);
    chk("t5_set_present_active", int'(a_active), 1);
    upd(0, 1, 1, 3);
    wait_idle(0, n);
    chk("t5_bad_plane_cycles", n, 3);
    chk("t5_bad_plane_active", int'(a_active), 1);
    @(posedge clk); #1 a_gnt_req = 1;
    grant_latency(n);
    chk("t5_skip_latency", n - 1, 5);
    repeat (15) @(negedge clk);
    @(posedge clk); #1 a_gnt_req = 0;
    chk("t5_grant_count", gh.size(), 1);
    chk("t5_grant_host", gh.size() > 0 ? gh[0] : -1, 6);
    chk("t5_grant_plane", gp.size() > 0 ? gp[0] : -1, 2);
    gh.delete(); gp.delete();

    // Reset while a grant is being offered.
    a_gnt_ready = 0;
    upd(0, 1, 2, 1);
    @(posedge clk); #1 a_gnt_req = 1;
    grant_latency(n);
    chk("t6_grant_offered", int'(a_gnt_valid), 1);
    #2 rst_n = 0;
    #1 chk("t6_async_valid_drop", int'(a_gnt_valid), 0);
    a_gnt_req = 0;
    @(posedge clk); @(posedge clk); #1 rst_n = 1;
    a_gnt_req = 1; a_gnt_ready = 1;
    repeat (10) @(negedge clk);
    chk("t6_empty_after_reset", int'(a_active), 0);
    chk("t6_no_grant_after_reset", gh.size(), 0);
    upd(0, 1, 0, 0);
    n = 0;
    while (gh.size() < 1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1 a_gnt_req = 0;
    chk("t6_grant_host", gh.size() > 0 ? gh[0] : -1, 0);
    chk("t6_grant_plane", gp.size() > 0 ? gp[0] : -1, 0);
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
